// File: rtl/uart_baud_pkg.sv
// uart_baud_pkg: baud table, divider-limit helper and FSM encoding for uart_baud_ctrl
package uart_baud_pkg;
   localparam int BAUD_SEL_W = 3;
   localparam int BAUD_TABLE [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};
   typedef enum logic [1:0] {RUN, DRAIN, RELOAD} state_t;
   function automatic int baud_limit(input int board_freq, input int sel);
      return (board_freq + BAUD_TABLE[sel] * 8) / (BAUD_TABLE[sel] * 16) - 1;
   endfunction
endpackage

// File: rtl/baud_divider.sv
// baud_divider: oversample divider plus 16-phase bit counter with registered tick pulses
module baud_divider #(
   parameter int CNT_W = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             clear,
   input  logic [CNT_W-1:0] limit,
   output logic             bit_edge,
   output logic             tick_x16,
   output logic             tick_bit
);
   logic [CNT_W-1:0] div_cnt;
   logic [3:0]       sub_cnt;
   logic             wrap;
   assign wrap     = div_cnt == limit;
   assign bit_edge = wrap && sub_cnt == 4'hF;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         div_cnt  <= '0;
         sub_cnt  <= '0;
         tick_x16 <= 1'b0;
         tick_bit <= 1'b0;
      end else if (!enable) begin
         tick_x16 <= 1'b0;
         tick_bit <= 1'b0;
      end else if (clear) begin
         div_cnt  <= '0;
         sub_cnt  <= '0;
         tick_x16 <= 1'b0;
         tick_bit <= 1'b0;
      end else begin
         div_cnt  <= wrap ? '0 : div_cnt + 1'b1;
         sub_cnt  <= wrap ? sub_cnt + 4'd1 : sub_cnt;
         tick_x16 <= wrap;
         tick_bit <= bit_edge;
      end
endmodule

// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: programmable x16/bit tick scheduler with rate changes deferred to bit boundaries
module uart_baud_ctrl
   import uart_baud_pkg::*;
#(
   parameter int BOARD_FREQ  = 100000000,
   parameter int DEFAULT_SEL = 3,
   parameter int CNT_W       = 13
) (
   input  logic                  clk_board,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  sel_req,
   input  logic [BAUD_SEL_W-1:0] sel_val,
   output logic                  sel_busy,
   output logic                  sel_ack,
   output logic [BAUD_SEL_W-1:0] cur_sel,
   output logic                  tick_x16,
   output logic                  tick_bit
);
   state_t                state;
   logic [BAUD_SEL_W-1:0] pend_sel;
   logic [CNT_W-1:0]      limit_tab [8];
   logic                  bit_edge;
   for (genvar i = 0; i < 8; i++) begin : g_lim
      assign limit_tab[i] = CNT_W'(baud_limit(BOARD_FREQ, i));
   end
   baud_divider #(.CNT_W(CNT_W)) u_div (
      .clk      (clk_board),
      .rst_n    (reset),
      .enable   (enable),
      .clear    (state == RELOAD),
      .limit    (limit_tab[cur_sel]),
      .bit_edge (bit_edge),
      .tick_x16 (tick_x16),
      .tick_bit (tick_bit)
   );
   // busy stays high through the ack cycle, so a request landing there is dropped
   always_ff @(posedge clk_board or negedge reset)
      if (!reset) begin
         state    <= RUN;
         cur_sel  <= BAUD_SEL_W'(DEFAULT_SEL);
         pend_sel <= '0;
         sel_busy <= 1'b0;
         sel_ack  <= 1'b0;
      end else begin
         sel_ack <= 1'b0;
         if (enable)
            case (state)
               RUN:
                  if (sel_busy) sel_busy <= 1'b0;
                  else if (sel_req && sel_val != cur_sel) begin
                     pend_sel <= sel_val;
                     sel_busy <= 1'b1;
                     state    <= DRAIN;
                  end else if (sel_req) sel_ack <= 1'b1;
               DRAIN: if (bit_edge) state <= RELOAD;
               RELOAD: begin
                  cur_sel <= pend_sel;
                  sel_ack <= 1'b1;
                  state   <= RUN;
               end
               default: state <= RUN;
            endcase
      end
endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb_uart_baud_ctrl: directed, hand-timed checks of tick periods, deferred switching, freeze and reset
module tb_uart_baud_ctrl;
   logic       clk_board = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b1;
   logic       sel_req = 1'b0;
   logic [2:0] sel_val = 3'd0;
   logic       sel_busy, sel_ack, tick_x16, tick_bit;
   logic [2:0] cur_sel;
   int checks = 0;
   int errors = 0;
   int ack_total = 0;
   int n, snap;

   uart_baud_ctrl dut (
      .clk_board (clk_board),
      .reset     (reset),
      .enable    (enable),
      .sel_req   (sel_req),
      .sel_val   (sel_val),
      .sel_busy  (sel_busy),
      .sel_ack   (sel_ack),
      .cur_sel   (cur_sel),
      .tick_x16  (tick_x16),
      .tick_bit  (tick_bit)
   );

   always #5 clk_board = ~clk_board;
   always @(negedge clk_board) if (sel_ack === 1'b1) ack_total++;

   task automatic step();
      @(posedge clk_board);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // which: 0 = tick_x16, 1 = tick_bit, 2 = sel_ack; returns edges until seen (capped)
   task automatic wait_for(input int which, output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!(which == 0 ? tick_x16 === 1'b1 : which == 1 ? tick_bit === 1'b1 : sel_ack === 1'b1) && cnt < 20000);
   endtask

   initial begin
      step();
      step();
      chk("rst_outputs", {sel_busy, sel_ack, tick_x16, tick_bit}, 0);
      chk("rst_cur_sel", cur_sel, 3);
      reset = 1'b1;
      // scenario 1: 9600 -> 651-cycle x16 period, 10416-cycle bit period
      wait_for(0, n); chk("s1_first_x16", n, 651);
      wait_for(0, n); chk("s1_x16_period", n, 651);
      wait_for(1, n); chk("s1_first_bit", n, 9114);
      chk("s1_bit_coincident", tick_x16, 1);
      wait_for(1, n); chk("s1_bit_period", n, 10416);
      chk("s1_cur_sel", cur_sel, 3);
      // scenario 2: switch to 115200 mid-bit
      wait_for(0, n); wait_for(0, n);
      sel_req = 1'b1; sel_val = 3'd7;
      step();
      sel_req = 1'b0;
      chk("s2_busy_at_once", sel_busy, 1);
      wait_for(0, n); chk("s2_old_rate_kept", n, 650);
      wait_for(1, n); chk("s2_drain_to_bit", n, 8463);
      chk("s2_busy_at_boundary", {sel_busy, sel_ack, cur_sel}, {1'b1, 1'b0, 3'd3});
      step();
      chk("s2_ack_cycle", {sel_busy, sel_ack, cur_sel}, {1'b1, 1'b1, 3'd7});
      step();
      chk("s2_after_ack", {sel_busy, sel_ack}, 0);
      wait_for(0, n); chk("s2_new_first_x16", n, 53);
      wait_for(0, n); chk("s2_new_period", n, 54);
      // scenario 3: request for the rate already in use
      repeat (10) step();
      chk("s3_no_ack_yet", sel_ack, 0);
      sel_req = 1'b1; sel_val = 3'd7;
      step();
      sel_req = 1'b0;
      chk("s3_ack_pulse", {sel_busy, sel_ack}, {1'b0, 1'b1});
      step();
      chk("s3_ack_gone", sel_ack, 0);
      wait_for(0, n); chk("s3_phase_kept", n, 42);
      chk("s3_cur_sel", cur_sel, 7);
      // scenario 4: freeze 100 cycles during DRAIN
      sel_req = 1'b1; sel_val = 3'd6;
      step();
      sel_req = 1'b0;
      chk("s4_busy", sel_busy, 1);
      repeat (10) step();
      enable = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         chk("s4_quiet_when_off", {tick_x16, tick_bit, sel_ack}, 0);
      end
      enable = 1'b1;
      chk("s4_still_busy", {sel_busy, cur_sel}, {1'b1, 3'd7});
      wait_for(1, n); chk("s4_boundary_delayed", n, 691);
      step();
      chk("s4_ack", {sel_ack, cur_sel}, {1'b1, 3'd6});
      // scenario 6: second request while busy is dropped
      step();
      snap = ack_total;
      sel_req = 1'b1; sel_val = 3'd5;
      step();
      chk("s6_busy", sel_busy, 1);
      sel_val = 3'd0;
      repeat (5) step();
      sel_req = 1'b0;
      wait_for(2, n); chk("s6_ack_at_boundary", n, 1738);
      chk("s6_cur_sel_at_ack", cur_sel, 5);
      repeat (300) step();
      chk("s6_single_ack", ack_total - snap, 1);
      chk("s6_final_sel", {cur_sel, sel_busy}, {3'd5, 1'b0});
      // scenario 5: async reset while a switch to index 0 is pending
      sel_req = 1'b1; sel_val = 3'd0;
      step();
      sel_req = 1'b0;
      chk("s5_busy", sel_busy, 1);
      repeat (20) step();
      #2 reset = 1'b0;
      #1;
      chk("s5_async_clear", {sel_busy, sel_ack, tick_x16, tick_bit}, 0);
      chk("s5_default_sel", cur_sel, 3);
      step();
      reset = 1'b1;
      snap = ack_total;
      wait_for(0, n); chk("s5_first_x16", n, 651);
      wait_for(0, n); chk("s5_x16_period", n, 651);
      wait_for(1, n); chk("s5_first_bit", n, 9114);
      chk("s5_no_ack", ack_total - snap, 0);
      chk("s5_cur_sel", {cur_sel, sel_busy}, {3'd3, 1'b0});
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
